// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and entry type
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   ferr;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver write strobe and show-ahead read handshake
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ferr;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ferr;

  modport master (
    output wr_valid, wr_data, wr_ferr, rd_ready,
    input  rd_valid, rd_data, rd_ferr
  );

  modport slave (
    input  wr_valid, wr_data, wr_ferr, rd_ready,
    output rd_valid, rd_data, rd_ferr
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - storage array, synchronous write, asynchronous read
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  parameter  int WIDTH = UART_DATA_W + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with framing flag, occupancy and sticky overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  parameter  int AFULL  = 12,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_fifo_if.slave    bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic [DATA_W:0]   head;

  assign empty       = (count == CNT_W'(0));
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count >= CNT_W'(AFULL));

  assign bus.rd_valid = !empty;
  assign rd_en        = bus.rd_valid && bus.rd_ready;
  // A simultaneous read frees the slot, so a full FIFO still takes the byte.
  assign wr_en        = bus.wr_valid && (!full || rd_en);
  assign drop         = bus.wr_valid && full && !rd_en;

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({bus.wr_ferr, bus.wr_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign {bus.rd_ferr, bus.rd_data} = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop in the clearing cycle must not be lost.
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr;

  int total;
  int bad;

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(
    .DATA_W (8),
    .DEPTH  (16),
    .AFULL  (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic f);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_ferr  = f;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", bus.rd_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full_afull got=%0b%0b exp=00", full, almost_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b0);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL prefill_count got=%0d exp=5", count); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midreset_rd_valid got=%0b exp=0", bus.rd_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%0b exp=1", empty); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midreset_overflow got=%0b exp=0", overflow); end
    step();
    rst = 1'b1;
    step();
    push(8'hA5, 1'b0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL postreset_data got=%0b/%0h exp=1/a5", bus.rd_valid, bus.rd_data); end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL postreset_drain got=%0b exp=1", empty); end
  endtask

  task automatic test_order();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h11;
    bus.wr_ferr  = 1'b0;
    #1;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL order_no_bypass got=%0b exp=0", bus.rd_valid); end
    step();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11) begin bad++; $display("FAIL order_latency got=%0b/%0h exp=1/11", bus.rd_valid, bus.rd_data); end
    bus.wr_data = 8'h22;
    step();
    bus.wr_data = 8'h33;
    step();
    bus.wr_valid = 1'b0;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d[i]) begin bad++; $display("FAIL order_read%0d got=%0b/%0h exp=1/%0h", i, bus.rd_valid, bus.rd_data, exp_d[i]); end
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      total++; if (almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_afull n=%0d got=%0b", i + 1, almost_full); end
      total++; if (full !== (i + 1 == 16)) begin bad++; $display("FAIL fill_full n=%0d got=%0b", i + 1, full); end
    end
    push(8'hFF, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_overflow got=%0b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d exp=16", count); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin bad++; $display("FAIL drain%0d got=%0b/%0h exp=1/%0h", i, bus.rd_valid, bus.rd_data, i); end
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b/%0b exp=1/0", empty, bus.rd_valid); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    bus.rd_ready = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fullrw_count got=%0d/%0b exp=16/1", count, full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullrw_overflow got=%0b exp=0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h77 : 8'(8'h20 + i);
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin bad++; $display("FAIL fullrw_read%0d got=%0b/%0h exp=1/%0h", i, bus.rd_valid, bus.rd_data, e); end
      step();
    end
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_ferr();
    push(8'h5A, 1'b1);
    push(8'h5B, 1'b0);
    bus.rd_ready = 1'b1;
    total++; if (bus.rd_data !== 8'h5A || bus.rd_ferr !== 1'b1) begin bad++; $display("FAIL ferr_first got=%0h/%0b exp=5a/1", bus.rd_data, bus.rd_ferr); end
    step();
    total++; if (bus.rd_data !== 8'h5B || bus.rd_ferr !== 1'b0) begin bad++; $display("FAIL ferr_second got=%0h/%0b exp=5b/0", bus.rd_data, bus.rd_ferr); end
    step();
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ferr_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_overflow_clr_race();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL race_pre got=%0b exp=0", overflow); end
    overflow_clr = 1'b1;
    push(8'hEE, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL race_set_wins got=%0b exp=1", overflow); end
    step();
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL race_clear got=%0b exp=0", overflow); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL race_drain got=%0b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev;
    bus.rd_ready = 1'b1;
    prev = 8'h00;
    for (int i = 0; i < 40; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(i * 7 + 3);
      bus.wr_ferr  = i[0];
      #1;
      if (i > 0) begin
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev || bus.rd_ferr !== ~i[0]) begin bad++; $display("FAIL wrap_read%0d got=%0b/%0h/%0b exp=1/%0h/%0b", i, bus.rd_valid, bus.rd_data, bus.rd_ferr, prev, ~i[0]); end
      end
      total++; if (count > 5'd1) begin bad++; $display("FAIL wrap_count%0d got=%0d exp<=1", i, count); end
      prev = 8'(i * 7 + 3);
      step();
    end
    bus.wr_valid = 1'b0;
    total++; if (bus.rd_data !== prev) begin bad++; $display("FAIL wrap_last got=%0h exp=%0h", bus.rd_data, prev); end
    step();
    bus.rd_ready = 1'b0;
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL wrap_empty got=%0b/%0d exp=1/0", empty, count); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    overflow_clr = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_ferr  = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    test_reset();
    test_order();
    test_full_overflow();
    test_full_rw();
    test_ferr();
    test_overflow_clr_race();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
